// File: rtl/conv3d_ctrl_pkg.sv
// rtl/conv3d_ctrl_pkg.sv - state encoding, default geometry and width helpers for conv3d_frame_ctrl
package conv3d_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      STREAM,
      DRAIN,
      DONE
   } ctrl_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   localparam int FRAME_H_MAX_DEF   = 224;
   localparam int FRAME_W_MAX_DEF   = 224;
   localparam int DRAIN_TIMEOUT_DEF = 1024;

   localparam int DIM_H_W_DEF = clog2(FRAME_H_MAX_DEF) + 1;
   localparam int DIM_W_W_DEF = clog2(FRAME_W_MAX_DEF) + 1;
   localparam int NPIX_W_DEF  = clog2(FRAME_H_MAX_DEF * FRAME_W_MAX_DEF) + 1;
   localparam int TMO_W_DEF   = clog2(DRAIN_TIMEOUT_DEF) + 1;

endpackage

// File: rtl/conv3d_frame_ctrl_cnt.sv
// rtl/conv3d_frame_ctrl_cnt.sv - loadable up-counter with terminal compare on its next value
module conv3d_frame_ctrl_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   input  logic [W-1:0] term_i,
   output logic [W-1:0] cnt_o,
   output logic         hit_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   // hit fires in the cycle whose increment lands on term, so callers can act without a lag cycle
   assign hit_o = inc_i && !load_i && ((cnt_q + W'(1)) == term_i);

endmodule

// File: rtl/conv3d_frame_ctrl.sv
// rtl/conv3d_frame_ctrl.sv - frame job sequencer for the conv3d datapath (perf counters under CONV3D_FRAME_CTRL_PERF_EN)
module conv3d_frame_ctrl
   import conv3d_ctrl_pkg::*;
#(
   parameter  int FRAME_H_MAX   = FRAME_H_MAX_DEF,
   parameter  int FRAME_W_MAX   = FRAME_W_MAX_DEF,
   parameter  int DIN_WIDTH     = 8,
   parameter  int CHANNELS_IN   = 4,
   parameter  int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
   localparam int DIM_H_W       = clog2(FRAME_H_MAX) + 1,
   localparam int DIM_W_W       = clog2(FRAME_W_MAX) + 1,
   localparam int NPIX_W        = clog2(FRAME_H_MAX * FRAME_W_MAX) + 1,
   localparam int TMO_W         = clog2(DRAIN_TIMEOUT) + 1,
   localparam int PIX_W         = CHANNELS_IN * DIN_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_vld,
   output logic               cmd_rdy,
   input  logic [DIM_H_W-1:0] cmd_frame_h,
   input  logic [DIM_W_W-1:0] cmd_frame_w,
   input  logic               pix_vld,
   output logic               pix_rdy,
   input  logic [PIX_W-1:0]   pix_data,
   output logic [DIM_H_W-1:0] frame_h,
   output logic [DIM_W_W-1:0] frame_w,
   output logic               frame_start,
   output logic               din_vld,
   output logic [PIX_W-1:0]   din,
   input  logic               conv_dout_vld,
   output logic               busy,
   output logic               job_done,
   output logic               job_err
`ifdef CONV3D_FRAME_CTRL_PERF_EN
   ,
   output logic [31:0]        perf_stall_cyc,
   output logic [31:0]        perf_drain_cyc,
   output logic [15:0]        perf_jobs
`endif
);

   ctrl_state_e        state_q, state_d;
   logic [DIM_H_W-1:0] frame_h_q, frame_h_d;
   logic [DIM_W_W-1:0] frame_w_q, frame_w_d;
   logic [NPIX_W-1:0]  npix_q, npix_d;
   logic               err_q, err_d;
   logic [PIX_W-1:0]   din_q;
   logic               din_vld_q;

   logic [NPIX_W-1:0]  in_cnt, out_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic               in_hit, out_hit, tmo_hit;
   logic               cmd_acc, cmd_ok, pix_acc, out_inc, out_done, timeout;

   assign cmd_rdy     = (state_q == IDLE) && !reset;
   assign pix_rdy     = (state_q == STREAM) && (in_cnt < npix_q);
   assign frame_start = (state_q == START);
   assign busy        = (state_q != IDLE);
   assign job_done    = (state_q == DONE);
   assign job_err     = (state_q == DONE) && err_q;
   assign frame_h     = frame_h_q;
   assign frame_w     = frame_w_q;
   assign din         = din_q;
   assign din_vld     = din_vld_q;

   assign cmd_acc  = cmd_vld && cmd_rdy;
   assign cmd_ok   = (cmd_frame_h != '0) && (cmd_frame_h <= DIM_H_W'(FRAME_H_MAX)) &&
                     (cmd_frame_w != '0) && (cmd_frame_w <= DIM_W_W'(FRAME_W_MAX));
   assign pix_acc  = pix_vld && pix_rdy;
   assign out_inc  = conv_dout_vld && ((state_q == STREAM) || (state_q == DRAIN));
   assign out_done = out_hit || (out_cnt == npix_q);
   assign timeout  = tmo_hit || (tmo_cnt == TMO_W'(DRAIN_TIMEOUT));

   conv3d_frame_ctrl_cnt #(.W(NPIX_W)) u_in_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (state_q == START),
      .load_val_i ('0),
      .inc_i      (pix_acc),
      .term_i     (npix_q),
      .cnt_o      (in_cnt),
      .hit_o      (in_hit)
   );

   conv3d_frame_ctrl_cnt #(.W(NPIX_W)) u_out_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (state_q == START),
      .load_val_i ('0),
      .inc_i      (out_inc),
      .term_i     (npix_q),
      .cnt_o      (out_cnt),
      .hit_o      (out_hit)
   );

   // held at zero outside DRAIN so the idle window only starts once the last pixel is in
   conv3d_frame_ctrl_cnt #(.W(TMO_W)) u_tmo_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     ((state_q != DRAIN) || conv_dout_vld),
      .load_val_i ('0),
      .inc_i      ((state_q == DRAIN) && !conv_dout_vld),
      .term_i     (TMO_W'(DRAIN_TIMEOUT)),
      .cnt_o      (tmo_cnt),
      .hit_o      (tmo_hit)
   );

   always_comb begin
      state_d   = state_q;
      frame_h_d = frame_h_q;
      frame_w_d = frame_w_q;
      npix_d    = npix_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (cmd_acc) begin
               if (cmd_ok) begin
                  frame_h_d = cmd_frame_h;
                  frame_w_d = cmd_frame_w;
                  npix_d    = NPIX_W'(cmd_frame_h) * NPIX_W'(cmd_frame_w);
                  err_d     = 1'b0;
                  state_d   = START;
               end else begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         START:  state_d = STREAM;
         STREAM: if (in_hit) state_d = DRAIN;
         DRAIN: begin
            if (out_done) begin
               err_d   = 1'b0;
               state_d = DONE;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         frame_h_q <= '0;
         frame_w_q <= '0;
         npix_q    <= '0;
         err_q     <= 1'b0;
         din_q     <= '0;
         din_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_h_q <= frame_h_d;
         frame_w_q <= frame_w_d;
         npix_q    <= npix_d;
         err_q     <= err_d;
         din_vld_q <= pix_acc;
         if (pix_acc) din_q <= pix_data;
      end
   end

`ifdef CONV3D_FRAME_CTRL_PERF_EN
   logic [31:0] stall_q, drain_q;
   logic [15:0] jobs_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         drain_q <= '0;
         jobs_q  <= '0;
      end else begin
         if (pix_rdy && !pix_vld && (stall_q != '1)) stall_q <= stall_q + 32'd1;
         if ((state_q == DRAIN) && (drain_q != '1)) drain_q <= drain_q + 32'd1;
         if (job_done && !err_q && (jobs_q != '1)) jobs_q <= jobs_q + 16'd1;
      end
   end

   assign perf_stall_cyc = stall_q;
   assign perf_drain_cyc = drain_q;
   assign perf_jobs      = jobs_q;
`endif

endmodule

// File: tb/tb_conv3d_frame_ctrl.sv
// tb/tb_conv3d_frame_ctrl.sv - self-checking bench for conv3d_frame_ctrl with a pixel scoreboard
module tb_conv3d_frame_ctrl;

   localparam int HMAX  = 224;
   localparam int WMAX  = 224;
   localparam int TMO   = 16;
   localparam int DIM_W = 9;
   localparam int PIX_W = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_vld = 1'b0;
   logic             cmd_rdy;
   logic [DIM_W-1:0] cmd_frame_h = '0;
   logic [DIM_W-1:0] cmd_frame_w = '0;
   logic             pix_vld = 1'b0;
   logic             pix_rdy;
   logic [PIX_W-1:0] pix_data = '0;
   logic [DIM_W-1:0] frame_h;
   logic [DIM_W-1:0] frame_w;
   logic             frame_start;
   logic             din_vld;
   logic [PIX_W-1:0] din;
   logic             conv_dout_vld = 1'b0;
   logic             busy;
   logic             job_done;
   logic             job_err;
`ifdef CONV3D_FRAME_CTRL_PERF_EN
   logic [31:0]      perf_stall_cyc;
   logic [31:0]      perf_drain_cyc;
   logic [15:0]      perf_jobs;
`endif

   conv3d_frame_ctrl #(
      .FRAME_H_MAX   (HMAX),
      .FRAME_W_MAX   (WMAX),
      .DIN_WIDTH     (8),
      .CHANNELS_IN   (4),
      .DRAIN_TIMEOUT (TMO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_vld       (cmd_vld),
      .cmd_rdy       (cmd_rdy),
      .cmd_frame_h   (cmd_frame_h),
      .cmd_frame_w   (cmd_frame_w),
      .pix_vld       (pix_vld),
      .pix_rdy       (pix_rdy),
      .pix_data      (pix_data),
      .frame_h       (frame_h),
      .frame_w       (frame_w),
      .frame_start   (frame_start),
      .din_vld       (din_vld),
      .din           (din),
      .conv_dout_vld (conv_dout_vld),
      .busy          (busy),
      .job_done      (job_done),
      .job_err       (job_err)
`ifdef CONV3D_FRAME_CTRL_PERF_EN
      ,
      .perf_stall_cyc(perf_stall_cyc),
      .perf_drain_cyc(perf_drain_cyc),
      .perf_jobs     (perf_jobs)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] cyc;
   } sb_t;

   sb_t exp_q[$];
   sb_t obs_q[$];

   int   cyc = 0, cmd_acc_cnt = 0, cmd_acc_cyc = 0, acc_cnt = 0;
   int   fs_cnt = 0, fs_cyc = 0, fs_overlap = 0, done_cnt = 0, done_cyc = 0;
   int   busy_cnt = 0, last_out_cyc = 0;
   logic done_err = 1'b0;
   int   n_checks = 0, n_fail = 0;

   // monitor: records events and the expected/observed pixel streams; all comparisons live in the tests
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!reset && cmd_vld && cmd_rdy) begin
         cmd_acc_cnt = cmd_acc_cnt + 1;
         cmd_acc_cyc = cyc;
      end
      if (!reset && pix_vld && pix_rdy) begin
         exp_q.push_back({pix_data, 32'(cyc)});
         acc_cnt = acc_cnt + 1;
      end
      if (din_vld === 1'b1) obs_q.push_back({din, 32'(cyc)});
      if (frame_start === 1'b1) begin
         fs_cnt = fs_cnt + 1;
         fs_cyc = cyc;
         if (din_vld === 1'b1) fs_overlap = fs_overlap + 1;
      end
      if (job_done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
         done_err = job_err;
      end
      if (busy === 1'b1) busy_cnt = busy_cnt + 1;
      if (conv_dout_vld) last_out_cyc = cyc;
   end

   task automatic send_cmd(input int h, input int w, output bit ok);
      int base = cmd_acc_cnt;
      ok = 1'b0;
      @(posedge clk); #1;
      cmd_vld = 1'b1;
      cmd_frame_h = DIM_W'(h);
      cmd_frame_w = DIM_W'(w);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (cmd_acc_cnt != base) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      cmd_vld = 1'b0;
   endtask

   task automatic feed_pixels(input int n, input int pct, output bit ok);
      int base = acc_cnt;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         pix_vld  = (int'($urandom_range(99)) < pct);
         pix_data = $urandom;
         @(negedge clk); #1;
         if (acc_cnt - base >= n) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      pix_vld = 1'b0;
   endtask

   task automatic feed_outputs(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         conv_dout_vld = 1'b1;
      end
      @(posedge clk); #1;
      conv_dout_vld = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > base) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      n_checks++;
      if (cmd_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cmd_rdy_in_reset: got %b expected 0", cmd_rdy);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if ({cmd_rdy, pix_rdy, frame_start, din_vld, busy, job_done, job_err} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 1000000",
                  {cmd_rdy, pix_rdy, frame_start, din_vld, busy, job_done, job_err});
      end
      n_checks++;
      if (frame_h !== '0 || frame_w !== '0 || din !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got h=%0d w=%0d din=%h expected 0 0 0", frame_h, frame_w, din);
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_nominal();
      bit ok;
      int dbase = done_cnt, bbase = busy_cnt;
      sb_t e, o;
      send_cmd(4, 5, ok);
      feed_pixels(20, 100, ok);
      feed_outputs(20);
      wait_done(dbase, 40, ok);
      n_checks++;
      if (!ok || done_err !== 1'b0) begin
         n_fail++;
         $display("FAIL nominal_done: got done=%0d err=%b expected done=1 err=0", ok, done_err);
      end
      n_checks++;
      if (fs_cyc !== cmd_acc_cyc + 1 || fs_overlap !== 0) begin
         n_fail++;
         $display("FAIL nominal_frame_start: got cyc %0d overlap %0d expected cyc %0d overlap 0",
                  fs_cyc, fs_overlap, cmd_acc_cyc + 1);
      end
      n_checks++;
      if (busy_cnt - bbase !== done_cyc - cmd_acc_cyc) begin
         n_fail++;
         $display("FAIL nominal_busy: got %0d busy cycles expected %0d", busy_cnt - bbase, done_cyc - cmd_acc_cyc);
      end
      n_checks++;
      if (obs_q.size() !== 20 || obs_q[obs_q.size()-1].cyc - obs_q[0].cyc !== 32'd19) begin
         n_fail++;
         $display("FAIL nominal_din_burst: got %0d beats expected 20 consecutive", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o.data !== e.data || o.cyc !== e.cyc + 1) begin
            n_fail++;
            $display("FAIL nominal_din: got %h@%0d expected %h@%0d", o.data, o.cyc, e.data, e.cyc + 1);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int dbase = done_cnt, abase;
      sb_t e, o;
      exp_q.delete();
      obs_q.delete();
      send_cmd(3, 3, ok);
      feed_pixels(9, 50, ok);
      abase = acc_cnt;
      @(negedge clk); #1;
      n_checks++;
      if (!ok || pix_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_pix_rdy_drop: got pix_rdy=%b fed=%0d expected pix_rdy=0 fed=1", pix_rdy, ok);
      end
      @(posedge clk); #1;
      pix_vld = 1'b1;
      repeat (3) @(posedge clk);
      #1 pix_vld = 1'b0;
      n_checks++;
      if (acc_cnt !== abase) begin
         n_fail++;
         $display("FAIL bp_extra_accept: got %0d accepts expected %0d", acc_cnt, abase);
      end
      feed_outputs(9);
      wait_done(dbase, 40, ok);
      n_checks++;
      if (!ok || done_err !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_done: got done=%0d err=%b expected done=1 err=0", ok, done_err);
      end
      n_checks++;
      if (exp_q.size() !== 9 || obs_q.size() !== 9) begin
         n_fail++;
         $display("FAIL bp_count: got exp=%0d obs=%0d expected 9 9", exp_q.size(), obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o.data !== e.data || o.cyc !== e.cyc + 1) begin
            n_fail++;
            $display("FAIL bp_din: got %h@%0d expected %h@%0d", o.data, o.cyc, e.data, e.cyc + 1);
         end
      end
   endtask

   task automatic test_illegal();
      bit ok;
      int dbase, fbase;
      int bad_h[2] = '{0, 4};
      int bad_w[2] = '{5, WMAX + 1};
      for (int k = 0; k < 2; k++) begin
         dbase = done_cnt;
         fbase = fs_cnt;
         send_cmd(bad_h[k], bad_w[k], ok);
         wait_done(dbase, 4, ok);
         n_checks++;
         if (!ok || done_err !== 1'b1 || done_cyc - cmd_acc_cyc > 2) begin
            n_fail++;
            $display("FAIL illegal_%0d_done: got done=%0d err=%b lat=%0d expected done=1 err=1 lat<=2",
                     k, ok, done_err, done_cyc - cmd_acc_cyc);
         end
         repeat (3) @(negedge clk);
         #1;
         n_checks++;
         if (fs_cnt !== fbase || frame_h !== 9'd3 || frame_w !== 9'd3) begin
            n_fail++;
            $display("FAIL illegal_%0d_geom: got starts=%0d h=%0d w=%0d expected starts=%0d h=3 w=3",
                     k, fs_cnt - fbase, frame_h, frame_w, 0);
         end
      end
   endtask

   task automatic test_drain_timeout();
      bit ok;
      int dbase = done_cnt;
      send_cmd(2, 2, ok);
      feed_pixels(4, 100, ok);
      feed_outputs(3);
      wait_done(dbase, 60, ok);
      n_checks++;
      if (!ok || done_err !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_err: got done=%0d err=%b expected done=1 err=1", ok, done_err);
      end
      n_checks++;
      if (done_cyc - last_out_cyc !== TMO + 1) begin
         n_fail++;
         $display("FAIL tmo_latency: got %0d expected %0d", done_cyc - last_out_cyc, TMO + 1);
      end
   endtask

   task automatic test_reset_mid_stream();
      bit ok;
      int dbase = done_cnt;
      sb_t e, o;
      send_cmd(4, 5, ok);
      feed_pixels(5, 100, ok);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if ({cmd_rdy, pix_rdy, frame_start, din_vld, busy, job_done, job_err} !== 7'b1000000 ||
          frame_h !== '0 || frame_w !== '0 || din !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got ctl=%b h=%0d w=%0d din=%h expected ctl=1000000 h=0 w=0 din=0",
                  {cmd_rdy, pix_rdy, frame_start, din_vld, busy, job_done, job_err}, frame_h, frame_w, din);
      end
      repeat (30) @(negedge clk);
      #1;
      n_checks++;
      if (done_cnt !== dbase) begin
         n_fail++;
         $display("FAIL midreset_no_done: got %0d job_done expected 0", done_cnt - dbase);
      end
      exp_q.delete();
      obs_q.delete();
      send_cmd(2, 3, ok);
      feed_pixels(6, 70, ok);
      feed_outputs(6);
      wait_done(dbase, 40, ok);
      n_checks++;
      if (!ok || done_err !== 1'b0 || exp_q.size() !== 6 || obs_q.size() !== 6) begin
         n_fail++;
         $display("FAIL midreset_rerun: got done=%0d err=%b exp=%0d obs=%0d expected 1 0 6 6",
                  ok, done_err, exp_q.size(), obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o.data !== e.data || o.cyc !== e.cyc + 1) begin
            n_fail++;
            $display("FAIL midreset_din: got %h@%0d expected %h@%0d", o.data, o.cyc, e.data, e.cyc + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int dbase = done_cnt, cbase = cmd_acc_cnt;
      int first_done;
      sb_t e, o;
      exp_q.delete();
      obs_q.delete();
      @(posedge clk); #1;
      cmd_vld = 1'b1;
      cmd_frame_h = 9'd2;
      cmd_frame_w = 9'd2;
      for (int i = 0; i < 10 && cmd_acc_cnt == cbase; i++) begin
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      cmd_frame_h = 9'd3;
      cmd_frame_w = 9'd2;
      feed_pixels(4, 100, ok);
      feed_outputs(4);
      wait_done(dbase, 40, ok);
      first_done = done_cyc;
      n_checks++;
      if (!ok || done_err !== 1'b0 || frame_h !== 9'd2 || frame_w !== 9'd2) begin
         n_fail++;
         $display("FAIL b2b_first: got done=%0d err=%b h=%0d w=%0d expected 1 0 2 2", ok, done_err, frame_h, frame_w);
      end
      for (int i = 0; i < 10 && cmd_acc_cnt == cbase + 1; i++) begin
         @(negedge clk); #1;
      end
      n_checks++;
      if (cmd_acc_cnt !== cbase + 2 || cmd_acc_cyc !== first_done + 1) begin
         n_fail++;
         $display("FAIL b2b_accept: got accept cyc %0d expected %0d", cmd_acc_cyc, first_done + 1);
      end
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (frame_h !== 9'd3 || frame_w !== 9'd2) begin
         n_fail++;
         $display("FAIL b2b_geom: got h=%0d w=%0d expected 3 2", frame_h, frame_w);
      end
      feed_pixels(6, 100, ok);
      feed_outputs(6);
      wait_done(dbase + 1, 40, ok);
      n_checks++;
      if (!ok || done_err !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second: got done=%0d err=%b expected 1 0", ok, done_err);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o.data !== e.data || o.cyc !== e.cyc + 1) begin
            n_fail++;
            $display("FAIL b2b_din: got %h@%0d expected %h@%0d", o.data, o.cyc, e.data, e.cyc + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_illegal();
      test_drain_timeout();
      test_reset_mid_stream();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/conv3d_frame_ctrl.md
Name: conv3d_frame_ctrl

Overview:
- Job sequencer in front of the conv3d datapath: row buffer, window/pad and per-output-channel kernels.
- Accepts one frame job (height, width) per command handshake, then drives the datapath's frame geometry, frame_start and din_vld/din from a back-pressured pixel stream.
- Counts pixels in, then waits for the datapath to emit every output pixel before reporting done.
- Only one frame is in flight at a time, so frame_h/frame_w never change under a running frame.

Parameters:
- FRAME_H_MAX, 224, maximum frame height.
- FRAME_W_MAX, 224, maximum frame width.
- DIN_WIDTH, 8, bits per input channel sample.
- CHANNELS_IN, 4, input channels per pixel.
- DRAIN_TIMEOUT, 1024, idle cycles allowed between output pixels in DRAIN before abort.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_vld  in  1  job command valid.
- cmd_rdy  out  1  controller can accept a job.
- cmd_frame_h  in  clog2(FRAME_H_MAX)+1  job height.
- cmd_frame_w  in  clog2(FRAME_W_MAX)+1  job width.
- pix_vld  in  1  input pixel valid.
- pix_rdy  out  1  input pixel accepted when pix_vld & pix_rdy.
- pix_data  in  CHANNELS_IN*DIN_WIDTH  input pixel, all channels.
- frame_h  out  clog2(FRAME_H_MAX)+1  height to datapath, held for the whole job.
- frame_w  out  clog2(FRAME_W_MAX)+1  width to datapath, held for the whole job.
- frame_start  out  1  one-cycle pulse to datapath.
- din_vld  out  1  pixel valid to datapath.
- din  out  CHANNELS_IN*DIN_WIDTH  pixel to datapath.
- conv_dout_vld  in  1  output-valid of datapath channel 0.
- busy  out  1  high in any state except IDLE.
- job_done  out  1  one-cycle pulse at end of job.
- job_err  out  1  qualifies job_done: job rejected or timed out.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous, active-high, on port reset.
- Reset values: state=IDLE; cmd_rdy=0 in the reset cycle, 1 from the first cycle after reset. pix_rdy, frame_start, din_vld, busy, job_done, job_err = 0. frame_h=0, frame_w=0, din=0.
- Reset mid-job aborts immediately. No job_done is issued and counters clear.
- Counter widths:
  - npix = frame_h*frame_w, computed at latch, width clog2(FRAME_H_MAX*FRAME_W_MAX)+1.
  - in_cnt and out_cnt have the same width as npix.
  - tmo_cnt has width clog2(DRAIN_TIMEOUT)+1.
- IDLE:
  - cmd_rdy=1.
  - On cmd_vld, check the command. If cmd_frame_h or cmd_frame_w is 0, or exceeds its MAX, go to DONE with the error flag set; frame_h/frame_w are not updated.
  - Otherwise latch frame_h and frame_w, compute npix, and go to START.
  - cmd_rdy=0 in every other state.
- START (1 cycle):
  - frame_start=1; in_cnt=0, out_cnt=0.
  - Go to STREAM.
- STREAM:
  - pix_rdy=1 while in_cnt<npix.
  - Each pix_vld&pix_rdy registers pix_data to din with din_vld=1 the next cycle, then in_cnt++. Latency pix→din is 1 cycle.
  - din_vld is never asserted in the cycle frame_start is asserted.
  - When in_cnt reaches npix, drop pix_rdy in the same cycle the last pixel is accepted, and go to DRAIN.
  - Gaps in pix_vld are passed through as din_vld=0.
- Output counting (STREAM and DRAIN): out_cnt increments on each conv_dout_vld. If an output arrives in the same cycle as an input, both counters update.
- DRAIN:
  - tmo_cnt clears on each conv_dout_vld and increments otherwise.
  - If out_cnt reaches npix, go to DONE with no error.
  - If tmo_cnt reaches DRAIN_TIMEOUT, go to DONE with the error flag set.
- DONE (1 cycle):
  - job_done=1; job_err = error flag.
  - Go to IDLE.
  - The earliest next cmd accept is the following cycle.
- conv_dout_vld outside STREAM/DRAIN is ignored.

Optional Feature:
- Macro: CONV3D_FRAME_CTRL_PERF_EN.
- When defined, add three outputs:
  - perf_stall_cyc [31:0]: STREAM cycles with pix_rdy & !pix_vld.
  - perf_drain_cyc [31:0]: cycles in DRAIN.
  - perf_jobs [15:0]: completed jobs without error.
- All three clear on reset, saturate at max, and are never cleared per job.
- When not defined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- functions_pkg: clog2 (already present).
- conv3d_ctrl_pkg:
  - state enum: IDLE, START, STREAM, DRAIN, DONE.
  - localparam widths for dimension, pixel-count and timeout counters.
- One natural sub-module: conv3d_frame_ctrl_cnt. This is a loadable up-counter with terminal-compare output, instantiated for in_cnt, out_cnt and tmo_cnt.

Test Plan:
- Nominal job, h=4, w=5, pix_vld always high:
  - frame_start is 1 cycle after cmd accept.
  - 20 din_vld, consecutive.
  - Feed 20 conv_dout_vld → job_done=1, job_err=0.
  - busy is high from cmd accept to DONE inclusive.
- Back-pressure, h=3, w=3, pix_vld toggled randomly:
  - din exactly equals the accepted pix_data sequence, delayed 1 cycle.
  - pix_rdy drops after the 9th accept.
- Illegal command, h=0 (and separately w=FRAME_W_MAX+1):
  - job_done=1, job_err=1 within 2 cycles.
  - No frame_start; frame_h/frame_w unchanged.
- Drain timeout, DRAIN_TIMEOUT=16, h=2, w=2, only 3 conv_dout_vld:
  - job_done with job_err=1 exactly 16 idle cycles after the last output.
- Reset asserted mid-STREAM after 5 of 20 pixels:
  - Next cycle all outputs are at reset values and there is no job_done.
  - A new job then runs cleanly.
- Back-to-back jobs, cmd_vld held high:
  - Second cmd accepted the cycle after job_done.
  - frame_h/frame_w stay stable until then.
